main_stage_ctrl: RTL and testbench
==================================

Name: main_stage_ctrl

Overview:
- Game-side responder to the menu's start/ready handshake.
- Accepts the menu's start request, then initialises stage state (lives, scroll, checkpoint, clear of an object-alive table).
- Acknowledges with ready on a frame boundary, then runs the frame-paced stage sequence: countdown, play, death, game-over, clear.
- Drives stage status to the sprite/background renderers and the top-level mux.

Parameters:
- CORDW, 16, width of the scroll position and speed.
- MAP_END, 12800, scroll position at which play stops advancing; goal is valid here.
- LIVES_INIT, 3, lives loaded on each start.
- COUNTDOWN_FRAMES, 120, frames between ready-release (or respawn) and play.
- DEATH_FRAMES, 60, frames held in the death animation.
- CHECKPOINT_STEP, 3200, checkpoint granularity for respawn scroll.
- OBJ_COUNT, 64, entries in the object-alive table (power of 2).

Ports:
- i_clk_pix  in  1  pixel clock; the only clock.
- i_rst  in  1  synchronous reset, active-high.
- i_frame  in  1  one-cycle pulse at start of vertical blank.
- i_main_start  in  1  start request from the menu; level, held until ready is seen.
- i_player_dead  in  1  one-cycle pulse from collision logic.
- i_goal  in  1  one-cycle pulse, player touched the goal.
- i_speed  in  CORDW  scroll increment per frame (unsigned).
- i_obj_kill  in  1  pulse: clear the alive bit of i_obj_idx.
- i_obj_idx  in  log2(OBJ_COUNT)  object index for kill/read.
- o_main_ready  out  1  handshake acknowledge to the menu.
- o_processing  out  1  high in every state except IDLE and GAME_OVER.
- o_playing  out  1  high only in PLAY.
- o_state  out  3  encoded current state, for debug/HUD.
- o_scroll  out  CORDW  current scroll position.
- o_lives  out  2  remaining lives.
- o_countdown  out  8  frames remaining in COUNTDOWN or DYING; 0 otherwise.
- o_obj_alive  out  1  alive bit of i_obj_idx, registered, latency 1.

Behaviour:
- Everything is registered on i_clk_pix. i_rst forces all of the following at the next edge, from any state, including mid-INIT:
  - state IDLE;
  - o_main_ready, o_playing and o_processing at 0;
  - o_scroll, checkpoint and o_countdown at 0;
  - o_lives at LIVES_INIT;
  - o_obj_alive at 0.
- States and encoding: IDLE=0, INIT=1, READY=2, COUNTDOWN=3, PLAY=4, DYING=5, GAME_OVER=6, CLEAR=7.
- IDLE:
  - i_main_start high moves to INIT.
  - The INIT entry cycle loads lives=LIVES_INIT, scroll=0, checkpoint=0 and clear index=0.
- INIT:
  - Writes alive=1 to one table entry per cycle; takes OBJ_COUNT cycles.
  - Then waits for the next i_frame. If i_frame arrives in the last write cycle, the entry is still written and the transition waits for the following frame.
  - On i_frame moves to READY.
  - If i_main_start drops during INIT (abort), returns to IDLE with no ready.
- READY:
  - o_main_ready=1.
  - When i_main_start is sampled low, moves to COUNTDOWN with countdown=COUNTDOWN_FRAMES; o_main_ready deasserts in the same cycle as the transition.
  - Ready is never asserted while start is low on entry. The menu therefore always sees ready before start drops: a 4-phase handshake.
- COUNTDOWN: each i_frame decrements countdown. On the frame where it reaches 0, moves to PLAY.
- PLAY:
  - Each i_frame sets scroll = min(scroll + i_speed, MAP_END). The sum is computed at CORDW+1 bits; overflow saturates to MAP_END.
  - checkpoint = scroll rounded down to a multiple of CHECKPOINT_STEP. It updates only when scroll crosses a multiple.
  - Priority on simultaneous events in one cycle: i_player_dead > i_goal > frame scroll update.
    - Death has priority: moves to DYING, countdown=DEATH_FRAMES, scroll not updated.
  - i_goal moves to CLEAR only when scroll==MAP_END; otherwise it is ignored.
- DYING:
  - Counts DEATH_FRAMES frames.
  - At 0: if lives==1, lives becomes 0 and the state moves to GAME_OVER. Otherwise lives decrements, scroll=checkpoint, and the state moves to COUNTDOWN with COUNTDOWN_FRAMES.
  - i_player_dead and i_goal are ignored outside PLAY.
- GAME_OVER and CLEAR: hold until i_rst. i_main_start is ignored; the menu is in its terminal state.
- Object table:
  - i_obj_kill writes 0 in every state except INIT. During INIT the clear sweep has priority and the kill is dropped.
  - Read is synchronous; o_obj_alive is valid 1 cycle after i_obj_idx.
  - An index out of range cannot occur (power-of-2 table).
- o_countdown mirrors the counter in COUNTDOWN and DYING, and is 0 elsewhere.

Test Plan:
- Reset, then raise start: INIT lasts exactly 64 cycles, then ready rises on the cycle after the next i_frame. Drop start: ready falls in 1 cycle and o_state=3, o_countdown=120.
- Drop start at INIT cycle 10 -> IDLE, o_main_ready never high, o_processing returns to 0.
- PLAY with i_speed=100 and scroll=12750, then one frame -> scroll=12800. A further frame -> still 12800. i_goal at 12700 is ignored; i_goal at 12800 -> o_state=7.
- Scroll 6500 (checkpoint 6400) plus i_player_dead and i_goal in the same cycle -> DYING. After 60 frames: lives 3→2, scroll=6400, o_state=3.
- Three deaths -> after the third DYING: o_lives=0, o_state=6, o_processing=0. Raising start again has no effect until i_rst.
- Kill object 5 in PLAY; read idx 5 -> o_obj_alive=0 next cycle, idx 6 reads 1. Assert i_rst mid-PLAY -> all outputs at reset values the next cycle. A subsequent start re-runs INIT and idx 5 reads 1.

Source files
------------

// File: rtl/main_stage_ctrl.sv
// main_stage_ctrl: menu start/ready responder and frame-paced stage sequencer; in: clk/rst/frame/start/death/goal/speed/kill/idx, out: ready/processing/playing/state/scroll/lives/countdown/obj_alive
module main_stage_ctrl #(
  parameter int CORDW = 16,
  parameter int MAP_END = 12800,
  parameter int LIVES_INIT = 3,
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int DEATH_FRAMES = 60,
  parameter int CHECKPOINT_STEP = 3200,
  parameter int OBJ_COUNT = 64
) (
  input  logic                         i_clk_pix,
  input  logic                         i_rst,
  input  logic                         i_frame,
  input  logic                         i_main_start,
  input  logic                         i_player_dead,
  input  logic                         i_goal,
  input  logic [CORDW-1:0]             i_speed,
  input  logic                         i_obj_kill,
  input  logic [$clog2(OBJ_COUNT)-1:0] i_obj_idx,
  output logic                         o_main_ready,
  output logic                         o_processing,
  output logic                         o_playing,
  output logic [2:0]                   o_state,
  output logic [CORDW-1:0]             o_scroll,
  output logic [1:0]                   o_lives,
  output logic [7:0]                   o_countdown,
  output logic                         o_obj_alive
);
  localparam int IW = $clog2(OBJ_COUNT);
  localparam logic [CORDW-1:0] END_C = CORDW'(MAP_END);
  localparam logic [CORDW-1:0] STEP_C = CORDW'(CHECKPOINT_STEP);
  localparam logic [7:0] CD_C = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] DF_C = 8'(DEATH_FRAMES);
  localparam logic [1:0] LI_C = 2'(LIVES_INIT);
  typedef enum logic [2:0] {IDLE, INIT, READY, COUNTDOWN, PLAY, DYING, GAME_OVER, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CORDW-1:0] scroll_q, scroll_d, ckpt_q, ckpt_d, scroll_nx;
  logic [CORDW:0] sum;
  logic [1:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic [IW-1:0] clr_q, clr_d;
  logic clr_done_q, clr_done_d;
  logic alive_q [OBJ_COUNT];
  logic obj_alive_q;
  logic last_tick;
  assign last_tick = i_frame && cnt_q <= 8'd1;
  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      state_q <= IDLE;
      scroll_q <= '0;
      ckpt_q <= '0;
      lives_q <= LI_C;
      cnt_q <= '0;
      clr_q <= '0;
      clr_done_q <= 1'b0;
      obj_alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scroll_q <= scroll_d;
      ckpt_q <= ckpt_d;
      lives_q <= lives_d;
      cnt_q <= cnt_d;
      clr_q <= clr_d;
      clr_done_q <= clr_done_d;
      obj_alive_q <= alive_q[i_obj_idx];
    end
  end
  // The INIT sweep owns the write port; kills arriving during INIT are dropped.
  always_ff @(posedge i_clk_pix) begin
    if (state_q == INIT && !clr_done_q) alive_q[clr_q] <= 1'b1;
    else if (state_q != INIT && i_obj_kill) alive_q[i_obj_idx] <= 1'b0;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_main_start) state_d = INIT;
      INIT:      if (!i_main_start) state_d = IDLE;
                 else if (clr_done_q && i_frame) state_d = READY;
      READY:     if (!i_main_start) state_d = COUNTDOWN;
      COUNTDOWN: if (last_tick) state_d = PLAY;
      PLAY:      if (i_player_dead) state_d = DYING;
                 else if (i_goal && scroll_q == END_C) state_d = CLEAR;
      DYING:     if (last_tick) state_d = lives_q == 2'd1 ? GAME_OVER : COUNTDOWN;
      default:   state_d = state_q;
    endcase
  end
  always_comb begin
    sum = {1'b0, scroll_q} + {1'b0, i_speed};
    scroll_nx = sum > {1'b0, END_C} ? END_C : sum[CORDW-1:0];
    scroll_d = scroll_q;
    ckpt_d = ckpt_q;
    lives_d = lives_q;
    cnt_d = cnt_q;
    clr_d = clr_q;
    clr_done_d = clr_done_q;
    case (state_q)
      IDLE: if (i_main_start) begin
        lives_d = LI_C;
        scroll_d = '0;
        ckpt_d = '0;
        clr_d = '0;
        clr_done_d = 1'b0;
      end
      INIT: if (!clr_done_q) begin
        clr_d = clr_q + IW'(1);
        clr_done_d = &clr_q;
      end
      READY: if (!i_main_start) cnt_d = CD_C;
      COUNTDOWN: if (i_frame) cnt_d = cnt_q - 8'd1;
      // At MAP_END a frame update is a no-op, so goal vs frame order is moot.
      PLAY: if (i_player_dead) cnt_d = DF_C;
      else if (i_frame) begin
        scroll_d = scroll_nx;
        ckpt_d = scroll_nx - scroll_nx % STEP_C;
      end
      DYING: if (i_frame) begin
        cnt_d = cnt_q - 8'd1;
        if (last_tick) begin
          lives_d = lives_q - 2'd1;
          if (lives_q != 2'd1) begin
            scroll_d = ckpt_q;
            cnt_d = CD_C;
          end
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end
  always_comb begin
    o_main_ready = state_q == READY;
    o_processing = state_q != IDLE && state_q != GAME_OVER;
    o_playing = state_q == PLAY;
    o_state = state_q;
    o_scroll = scroll_q;
    o_lives = lives_q;
    o_countdown = (state_q == COUNTDOWN || state_q == DYING) ? cnt_q : 8'd0;
    o_obj_alive = obj_alive_q;
  end
endmodule

// File: tb/tb_main_stage_ctrl.sv
// tb_main_stage_ctrl: directed self-checking bench for main_stage_ctrl
module tb_main_stage_ctrl;
  logic clk = 0, rst = 1, frame = 0, start = 0, dead = 0, goal = 0, kill = 0;
  logic [15:0] speed = 0;
  logic [5:0] idx = 0;
  logic ready, processing, playing, alive;
  logic [2:0] state;
  logic [15:0] scroll;
  logic [1:0] lives;
  logic [7:0] countdown;
  int n_cmp = 0, n_err = 0;
  main_stage_ctrl dut (
    .i_clk_pix(clk), .i_rst(rst), .i_frame(frame), .i_main_start(start),
    .i_player_dead(dead), .i_goal(goal), .i_speed(speed), .i_obj_kill(kill),
    .i_obj_idx(idx), .o_main_ready(ready), .o_processing(processing),
    .o_playing(playing), .o_state(state), .o_scroll(scroll), .o_lives(lives),
    .o_countdown(countdown), .o_obj_alive(alive)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      frame = 1;
      step();
      frame = 0;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".ready"}, ready, 0);
    chk({tag, ".proc"}, processing, 0);
    chk({tag, ".play"}, playing, 0);
    chk({tag, ".scroll"}, scroll, 0);
    chk({tag, ".cd"}, countdown, 0);
    chk({tag, ".lives"}, lives, 3);
    chk({tag, ".alive"}, alive, 0);
  endtask
  task automatic to_play();
    start = 1;
    step();
    repeat (64) step();
    frames(1);
    start = 0;
    step();
    frames(120);
  endtask
  initial begin
    step();
    step();
    rst = 0;
    chk_reset("rst0");
    start = 1;
    step();
    chk("abort.init", state, 1);
    chk("abort.proc", processing, 1);
    repeat (9) begin
      step();
      chk("abort.noready", ready, 0);
    end
    start = 0;
    step();
    chk("abort.idle", state, 0);
    chk("abort.proc0", processing, 0);
    chk("abort.ready", ready, 0);
    start = 1;
    step();
    repeat (63) begin
      step();
      chk("init.hold", state, 1);
    end
    frames(1);
    chk("init.lastframe", state, 1);
    step();
    chk("init.wait", state, 1);
    chk("init.noready", ready, 0);
    frames(1);
    chk("ready.state", state, 2);
    chk("ready.up", ready, 1);
    step();
    chk("ready.hold", ready, 1);
    start = 0;
    step();
    chk("ready.down", ready, 0);
    chk("cd.state", state, 3);
    chk("cd.val", countdown, 120);
    frames(119);
    chk("cd.last", countdown, 1);
    chk("cd.still", state, 3);
    frames(1);
    chk("play.state", state, 4);
    chk("play.flag", playing, 1);
    chk("play.cd0", countdown, 0);
    idx = 5;
    step();
    chk("obj5.pre", alive, 1);
    kill = 1;
    step();
    kill = 0;
    step();
    chk("obj5.killed", alive, 0);
    idx = 6;
    step();
    chk("obj6.alive", alive, 1);
    speed = 6500;
    frames(1);
    chk("scr.6500", scroll, 6500);
    dead = 1;
    goal = 1;
    frame = 1;
    step();
    dead = 0;
    goal = 0;
    frame = 0;
    chk("die1.state", state, 5);
    chk("die1.scroll", scroll, 6500);
    chk("die1.cd", countdown, 60);
    frames(59);
    chk("die1.cd1", countdown, 1);
    chk("die1.still", state, 5);
    frames(1);
    chk("resp1.state", state, 3);
    chk("resp1.lives", lives, 2);
    chk("resp1.scroll", scroll, 6400);
    chk("resp1.cd", countdown, 120);
    frames(120);
    chk("play2.state", state, 4);
    dead = 1;
    step();
    dead = 0;
    frames(60);
    chk("resp2.lives", lives, 1);
    chk("resp2.state", state, 3);
    frames(120);
    dead = 1;
    step();
    dead = 0;
    frames(60);
    chk("go.lives", lives, 0);
    chk("go.state", state, 6);
    chk("go.proc", processing, 0);
    start = 1;
    repeat (5) step();
    frames(2);
    chk("go.start", state, 6);
    chk("go.ready", ready, 0);
    start = 0;
    rst = 1;
    step();
    rst = 0;
    chk_reset("rst1");
    to_play();
    chk("replay.state", state, 4);
    idx = 5;
    step();
    step();
    chk("obj5.reinit", alive, 1);
    speed = 12700;
    frames(1);
    rst = 1;
    step();
    rst = 0;
    chk_reset("rst2");
    to_play();
    speed = 12700;
    frames(1);
    chk("scr.12700", scroll, 12700);
    goal = 1;
    step();
    goal = 0;
    chk("goal.ignored", state, 4);
    speed = 50;
    frames(1);
    chk("scr.12750", scroll, 12750);
    speed = 100;
    frames(1);
    chk("scr.sat", scroll, 12800);
    speed = 16'hFFFF;
    frames(1);
    chk("scr.ovf", scroll, 12800);
    goal = 1;
    step();
    goal = 0;
    chk("clear.state", state, 7);
    chk("clear.proc", processing, 1);
    chk("clear.play", playing, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
